// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - fetch/load-store arbiter for one shared single-port synchronous-read memory
module rv_mem_arbiter #(
  parameter int MEM_AW      = 12,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_t;

  localparam logic [3:0] L_MAX_STREAK = 4'(MAX_DSTREAK);

  owner_t            r_owner;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [3:0]        r_streak;

  logic              w_force_if;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_any_gnt;
  logic              w_d_write;
  logic [MEM_AW-1:0] w_if_word;
  logic [MEM_AW-1:0] w_d_word;
  logic              w_unused_addr_bits;

  // Data normally wins; fetch is forced once data has won MAX_DSTREAK times in a row against it.
  // Grants are held off entirely during reset so nothing reaches the memory.
  assign w_force_if = if_req_i && (r_streak == L_MAX_STREAK);
  assign w_d_gnt    = rst_n && d_req_i && !w_force_if;
  assign w_if_gnt   = rst_n && if_req_i && !w_d_gnt;
  assign w_any_gnt  = w_if_gnt || w_d_gnt;
  assign w_d_write  = w_d_gnt && d_we_i;

  assign if_gnt_o = w_if_gnt;
  assign d_gnt_o  = w_d_gnt;

  // Word index only; byte offset and bits above the array size are dropped, so addresses wrap.
  assign w_if_word = if_addr_i[MEM_AW+1:2];
  assign w_d_word  = d_addr_i[MEM_AW+1:2];
  assign w_unused_addr_bits = ^{if_addr_i[31:MEM_AW+2], if_addr_i[1:0],
                                d_addr_i[31:MEM_AW+2], d_addr_i[1:0]};

  assign mem_en_o    = w_any_gnt;
  assign mem_we_o    = w_d_write;
  assign mem_be_o    = w_d_write ? d_be_i : (w_any_gnt ? 4'hF : 4'h0);
  assign mem_addr_o  = w_d_gnt ? w_d_word : (w_if_gnt ? w_if_word : '0);
  assign mem_wdata_o = w_any_gnt ? d_wdata_i : 32'h0;

  // Count data wins while fetch waits; any fetch win or idle fetch port resets the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_streak <= 4'd0;
    end else if (!if_req_i || w_if_gnt) begin
      r_streak <= 4'd0;
    end else if (w_d_gnt && (r_streak != L_MAX_STREAK)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // Response owner FSM: remembers who was granted so next cycle's read data goes back to them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= OWN_NONE;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_d_rvalid  <= w_d_gnt;
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_d_gnt) begin
        r_owner <= d_we_i ? OWN_D_WR : OWN_D_RD;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign if_rvalid_o = r_if_rvalid;
  assign d_rvalid_o  = r_d_rvalid;

  // Read data is steered straight from the memory; write responses and idle cycles read as zero.
  assign if_rdata_o = (r_owner == OWN_IF)   ? mem_rdata_i : 32'h0;
  assign d_rdata_o  = (r_owner == OWN_D_RD) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - self-checking bench for rv_mem_arbiter with memory model and scoreboard
module tb_rv_mem_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int MAXS  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [31:0]   if_rdata_o;
  logic          d_req_i, d_we_i;
  logic [3:0]    d_be_i;
  logic [31:0]   d_addr_i, d_wdata_i;
  logic          d_gnt_o, d_rvalid_o;
  logic [31:0]   d_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i = 32'h0;

  rv_mem_arbiter #(.MEM_AW(AW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Write-first synchronous-read RAM attached to the memory port
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en_o) begin
      ram[mem_addr_o] <= mem_we_o ? merge(ram[mem_addr_o], mem_be_o, mem_wdata_o) : ram[mem_addr_o];
      mem_rdata_i     <= mem_we_o ? merge(ram[mem_addr_o], mem_be_o, mem_wdata_o) : ram[mem_addr_o];
    end
  end

  // Reference model state: shadow memory, starvation count, expected responses
  logic [31:0] shadow [DEPTH];
  int          m_streak;
  logic        m_if_rv, m_d_rv, m_gi, m_gd;
  logic [31:0] m_if_rd, m_d_rd;

  int n_err, n_chk;
  logic        o_if_gnt, o_d_gnt, o_d_rvalid;
  logic [31:0] o_if_rdata, o_d_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [9:0]  pat;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step(input bit drop_rst = 1'b0);
    logic gd, gi, men;
    int ia, da, ea;
    #2;
    gd  = rst_n && d_req_i && !(if_req_i && m_streak >= MAXS);
    gi  = rst_n && if_req_i && !gd;
    men = gd || gi;
    ia  = widx(if_addr_i);
    da  = widx(d_addr_i);
    ea  = gd ? da : (gi ? ia : 0);
    chk("if_gnt", if_gnt_o, gi);
    chk("d_gnt", d_gnt_o, gd);
    chk("if_rvalid", if_rvalid_o, m_if_rv);
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("d_rvalid", d_rvalid_o, m_d_rv);
    chk("d_rdata", d_rdata_o, m_d_rd);
    chk("mem_en", mem_en_o, men);
    chk("mem_we", mem_we_o, gd && d_we_i);
    chk("mem_be", mem_be_o, (gd && d_we_i) ? d_be_i : (men ? 4'hF : 4'h0));
    chk("mem_addr", mem_addr_o, ea);
    chk("mem_wdata", mem_wdata_o, men ? d_wdata_i : 32'h0);
    o_if_gnt = if_gnt_o; o_d_gnt = d_gnt_o; o_d_rvalid = d_rvalid_o;
    o_if_rdata = if_rdata_o; o_d_rdata = d_rdata_o; o_mem_addr = mem_addr_o;
    if (drop_rst) begin
      rst_n = 1'b0;
      gd = 1'b0;
      gi = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_streak = 0; m_if_rv = 1'b0; m_d_rv = 1'b0; m_if_rd = '0; m_d_rd = '0;
      m_gi = 1'b0; m_gd = 1'b0;
    end else begin
      m_if_rv = gi;
      m_if_rd = gi ? shadow[ia] : 32'h0;
      m_d_rv  = gd;
      if (gd && d_we_i) begin
        shadow[da] = merge(shadow[da], d_be_i, d_wdata_i);
        m_d_rd = 32'h0;
      end else begin
        m_d_rd = gd ? shadow[da] : 32'h0;
      end
      if (!if_req_i || gi) m_streak = 0;
      else if (gd && m_streak < MAXS) m_streak++;
      m_gi = gi; m_gd = gd;
    end
    @(negedge clk);
  endtask

  initial begin
    n_err = 0; n_chk = 0;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'h0; shadow[i] = 32'h0; end
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
    shadow[0] = 32'h11; shadow[1] = 32'h22; shadow[2] = 32'h33;
    rst_n = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    m_streak = 0; m_if_rv = 1'b0; m_d_rv = 1'b0; m_if_rd = '0; m_d_rd = '0;
    m_gi = 1'b0; m_gd = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset held two cycles with both requesting, then release
    step(); step();
    rst_n = 1'b1;
    step();
    chk("first_after_reset_d_gnt", o_d_gnt, 1'b1);
    if_req_i = 1'b0; d_req_i = 1'b0;
    step();

    // Fetch-only burst back-to-back
    if_req_i = 1'b1; if_addr_i = 32'h0; step();
    if_addr_i = 32'h4; step(); chk("fetch_data0", o_if_rdata, 32'h11);
    if_addr_i = 32'h8; step(); chk("fetch_data1", o_if_rdata, 32'h22);
    if_req_i = 1'b0;   step(); chk("fetch_data2", o_if_rdata, 32'h33);

    // Contention with both requests held
    if_req_i = 1'b1; if_addr_i = 32'h10; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
    pat = '0;
    for (int i = 0; i < 10; i++) begin step(); pat = {pat[8:0], o_if_gnt}; end
    chk("contention_pattern", pat, 10'b0000100001);
    if_req_i = 1'b0; d_req_i = 1'b0; step();

    // Byte write then readback of the same word
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0100; d_addr_i = 32'h102; d_wdata_i = 32'hAABBCCDD;
    step(); chk("byte_write_addr", o_mem_addr, 12'h040);
    d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h100;
    step(); chk("write_resp_valid", o_d_rvalid, 1'b1); chk("write_resp_data", o_d_rdata, 32'h0);
    d_req_i = 1'b0;
    step(); chk("byte_readback", o_d_rdata, 32'h00BB0000);

    // Address wrap beyond the array
    if_req_i = 1'b1; if_addr_i = 32'h0000_4008;
    step(); chk("wrap_addr", o_mem_addr, 12'h002);
    if_req_i = 1'b0; step();

    // Reset arriving at the edge that would capture a data read
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8;
    step(1'b1);
    chk("midop_rst_grant_seen", o_d_gnt, 1'b1);
    step(); chk("midop_rvalid_dropped", o_d_rvalid, 1'b0);
    rst_n = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h0;
    pat = '0;
    for (int i = 0; i < 5; i++) begin step(); pat = {pat[8:0], o_if_gnt}; end
    chk("streak_cleared_by_reset", pat[4:0], 5'b00001);
    if_req_i = 1'b0; d_req_i = 1'b0; step();

    // Randomized traffic; pending requests are held or withdrawn, never altered
    for (int n = 0; n < 400; n++) begin
      if (if_req_i && !m_gi) begin
        if ($urandom_range(0, 7) == 0) if_req_i = 1'b0;
      end else begin
        if_req_i  = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom & 32'h0000_C03F;
      end
      if (d_req_i && !m_gd) begin
        if ($urandom_range(0, 7) == 0) d_req_i = 1'b0;
      end else begin
        d_req_i   = ($urandom_range(0, 2) != 0);
        d_we_i    = $urandom_range(0, 1);
        d_be_i    = 4'($urandom);
        d_addr_i  = $urandom & 32'h0000_C03F;
        d_wdata_i = $urandom;
      end
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port. Arbitrates per cycle, with fixed data-over-fetch priority and a bounded-starvation guard for fetch. Routes the read data back to the granted requester one cycle after the grant. Sits between rv_core's IMEM/DMEM ports and the shared MEMORY array in the simulation top, and later the FPGA BRAM.

Parameters:
MEM_AW, 12, word-index width of the memory (4096 words).
MAX_DSTREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced (range 1..15).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_req_i  in  1  fetch request
if_addr_i  in  32  fetch byte address
if_gnt_o  out  1  fetch granted this cycle (combinational)
if_rvalid_o  out  1  fetch data valid
if_rdata_o  out  32  fetch data
d_req_i  in  1  data request
d_we_i  in  1  1 = write
d_be_i  in  4  byte enables for writes
d_addr_i  in  32  data byte address
d_wdata_i  in  32  write data
d_gnt_o  out  1  data granted this cycle (combinational)
d_rvalid_o  out  1  data response valid (reads and writes)
d_rdata_o  out  32  read data; 0 for write responses
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write
mem_be_o  out  4  memory byte enables
mem_addr_o  out  MEM_AW  word address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data, valid the cycle after mem_en_o

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, streak=0, resp_owner=NONE, and both rvalid outputs=0. The rdata outputs read 0 while their rvalid is 0.
- Grants are combinational from the requests and streak. At most one grant per cycle.
- Data beats fetch when both request. Exception: if streak==MAX_DSTREAK and if_req_i=1, fetch wins.
- Streak counter:
  - Increments on each data grant while if_req_i=1, saturating at MAX_DSTREAK.
  - Clears on a fetch grant, or on any cycle with if_req_i=0.
- Memory drive:
  - mem_en_o = if_gnt_o | d_gnt_o.
  - mem_addr_o = granted address [MEM_AW+1:2]; bits [1:0] and bits above are ignored, so accesses wrap.
  - mem_we_o = d_gnt_o & d_we_i.
  - mem_be_o = d_be_i on a data write, else 4'hF.
  - mem_wdata_o = d_wdata_i.
  - When idle, all mem_* outputs are 0.
- Response FSM, registered resp_owner with states NONE / IF / D_RD / D_WR, updated every cycle from that cycle's grant:
  - IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i.
  - D_RD: d_rvalid_o=1, d_rdata_o=mem_rdata_i.
  - D_WR: d_rvalid_o=1, d_rdata_o=0.
  - Latency is exactly 1 cycle from grant to rvalid. Back-to-back grants pipeline, giving one access per cycle.
- Requester rules:
  - Hold req/addr/we/be/wdata stable until gnt.
  - Deasserting req before gnt withdraws the request; no response follows.
  - A requester may re-request in the same cycle as its rvalid.
- Write then read of the same word in consecutive cycles returns the written data. The memory is write-first; the arbiter adds no bypass.
- Reset asserted mid-access: the pending rvalid is dropped, and any write granted in that cycle is not issued because grants are forced 0 while rst_n=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both reqs=1 -> gnt=0, rvalid=0, mem_en_o=0. First cycle after release: d_gnt_o=1.
- Fetch only: if_req_i=1, addr 0x0,0x4,0x8 back-to-back, memory preloaded with 0x11,0x22,0x33 -> if_gnt_o=1 each cycle; if_rvalid_o on cycles 1..3 with data 0x11,0x22,0x33 in order.
- Contention, MAX_DSTREAK=4, both reqs held -> grant sequence D,D,D,D,IF,D,D,D,D,IF; each rvalid goes to the correct port one cycle later.
- Byte write: d_we_i=1, d_be_i=4'b0100, addr 0x102, wdata 0xAABBCCDD over old word 0x00000000, then a read of 0x100 -> mem_addr_o=0x40, write rvalid with rdata=0, readback 0x00BB0000.
- Wrap: fetch addr 0x00004008 with MEM_AW=12 -> mem_addr_o=0x002.
- Mid-op reset: data read granted, rst_n=0 next edge -> d_rvalid_o stays 0, streak=0, resp_owner=NONE.
